float_divider_seq: RTL and testbench
====================================

FLOAT_DIVIDER_SEQ -- requirements
Module: float_divider_seq

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-004 The block SHALL have port a, input, 32 bits: IEEE-754 single-precision dividend; captured when start is accepted.
REQ-005 The block SHALL have port b, input, 32 bits: IEEE-754 single-precision divisor; captured when start is accepted.
REQ-006 The block SHALL have port result, output, 32 bits: quotient; holds its value until the next completion.
REQ-007 The block SHALL have port valid, output, 1 bit: one-cycle pulse marking the cycle in which result is updated.
REQ-008 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-009 The block SHALL have port div_by_zero, output, 1 bit: set with valid when b is zero and a is finite and nonzero; holds its value until the next completion.

Function
REQ-010 The FSM SHALL have states IDLE, DIV, NORM and DONE.
- IDLE -> DIV when start=1 and the operands are not special.
- IDLE -> DONE when start=1 and the operands are special.
- DIV -> NORM after the final iteration.
- NORM -> DONE.
- DONE -> IDLE unconditionally.
REQ-011 start SHALL be ignored outside IDLE; operands SHALL be registered on acceptance, so later changes on a and b have no effect.
REQ-012 Operands with exponent 0 SHALL be treated as zero (denormals flushed); sign = a[31] XOR b[31].
REQ-013 Special operands SHALL be resolved in the acceptance cycle, in this priority order:
- any NaN, 0/0 or inf/inf -> 32'h7FC00000;
- inf/finite -> {sign, 8'hFF, 0};
- finite nonzero/0 -> {sign, 8'hFF, 0} with div_by_zero=1;
- 0/nonzero or finite/inf -> {sign, 31'b0}.
REQ-014 For special operands, valid SHALL assert exactly one cycle after the accepting edge.
REQ-015 Mantissa division SHALL be restoring, one quotient bit per cycle in DIV.
- Mantissas are 24 bits, {1, frac}.
- Remainder starts at ma; each step: if rem >= mb, q bit = 1 and rem = rem - mb; then rem = rem << 1.
- 25 iterations give q[24:0], MSB first, with a 5-bit iteration counter.
REQ-016 The exponent SHALL be computed as exp_a - exp_b + 127 in 10-bit signed arithmetic.
- In NORM: if q[24]=1, frac = q[23:1] and the exponent is unchanged.
- Otherwise frac = q[22:0] and the exponent is decremented by 1.
REQ-017 After normalization, exponent >= 255 SHALL give {sign, 8'hFF, 0}, and exponent <= 0 SHALL give {sign, 31'b0}; div_by_zero=0 in both cases.
REQ-018 For normal operands, valid SHALL assert exactly 26 cycles after the accepting edge (27 with FDIV_ROUND_EN).
REQ-019 Only valid SHALL pulse.
- busy SHALL fall in the same cycle that valid is high is left (i.e. on the DONE -> IDLE edge).
- A start presented in the cycle after DONE SHALL be accepted.
REQ-020 The default rounding SHALL be truncation toward zero.

Reset
REQ-021 When rst_n=0, the block SHALL asynchronously force: state=IDLE, result=0, valid=0, busy=0, div_by_zero=0, counter=0, remainder=0, quotient=0.
REQ-022 A reset asserted mid-operation SHALL abort the operation with no valid pulse; the first start after reset release SHALL begin a fresh division.

Configuration
REQ-023 When macro FDIV_ROUND_EN is defined, the block SHALL apply round-to-nearest-even.
- One extra iteration (26 total) produces a guard bit; sticky = (final remainder != 0).
- Increment when guard=1 and (sticky=1 or lsb=1).
- A mantissa carry-out SHALL increment the exponent before the overflow check.
REQ-024 When FDIV_ROUND_EN is undefined, the block SHALL perform 25 iterations with truncation; no rounding logic SHALL be present.

Verification
REQ-025 The bench SHALL cover a=40C00000 (6.0), b=40000000 (2.0): result=40400000, valid exactly 26 cycles after start (27 rounded).
REQ-026 The bench SHALL cover a=3F800000, b=40400000 (1/3): result=3EAAAAAA without FDIV_ROUND_EN and 3EAAAAAB with it.
REQ-027 The bench SHALL cover a=BF800000, b=3F000000: result=C0000000; then a=3F800000, b=00000000: result=7F800000, div_by_zero=1, valid 1 cycle after start; then a=00000000, b=00000000: result=7FC00000.
REQ-028 The bench SHALL pulse start again 5 cycles into a 6.0/2.0 division with a=3F800000: it is ignored, result=40400000, only one valid pulse.
REQ-029 The bench SHALL assert rst_n=0 10 cycles into a division: all outputs 0 immediately, no valid; after release, a=7F000000, b=00800000: result=7F800000 (overflow) with div_by_zero=0.
REQ-030 The bench SHALL cover a=00800000, b=7F000000: result=00000000 (underflow flushed).

Source files
------------

// File: rtl/float_divider_seq.sv
// Sequential IEEE-754 single-precision divider: restoring mantissa division, one quotient bit per cycle.
// Optional macro FDIV_ROUND_EN adds a guard iteration and round-to-nearest-even; default truncates.
module float_divider_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        valid,
  output logic        busy,
  output logic        div_by_zero
);

`ifdef FDIV_ROUND_EN
  localparam int NITER = 26;
`else
  localparam int NITER = 25;
`endif

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;
  state_t state_q, state_d;

  logic [4:0]        cnt_q;
  logic [24:0]       rem_q;
  logic [NITER-1:0]  q_q;
  logic [23:0]       mb_q;
  logic signed [9:0] exp_q;
  logic              sign_q;
  logic              spec_q;
  logic              spec_dbz_q;
  logic [31:0]       spec_res_q;

  logic [7:0]  ea, eb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, special, in_sign;
  logic [31:0] spec_res;
  logic        spec_dbz;

  assign ea      = a[30:23];
  assign eb      = b[30:23];
  assign in_sign = a[31] ^ b[31];
  assign a_zero  = (ea == 8'h00);
  assign b_zero  = (eb == 8'h00);
  assign a_inf   = (ea == 8'hFF) && (a[22:0] == 23'd0);
  assign b_inf   = (eb == 8'hFF) && (b[22:0] == 23'd0);
  assign a_nan   = (ea == 8'hFF) && (a[22:0] != 23'd0);
  assign b_nan   = (eb == 8'hFF) && (b[22:0] != 23'd0);
  assign special = a_zero | b_zero | (ea == 8'hFF) | (eb == 8'hFF);

  always_comb begin
    spec_res = {in_sign, 31'd0};
    spec_dbz = 1'b0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res = 32'h7FC00000;
    end else if (a_inf) begin
      spec_res = {in_sign, 8'hFF, 23'd0};
    end else if (b_zero) begin
      spec_res = {in_sign, 8'hFF, 23'd0};
      spec_dbz = 1'b1;
    end
  end

  logic        last_iter;
  logic        ge;
  logic [23:0] rem_sub;

  assign last_iter = (cnt_q == 5'(NITER - 1));
  assign ge        = (rem_q >= {1'b0, mb_q});
  // After a restoring step the remainder is always below the divisor, so 24 bits hold it.
  assign rem_sub   = ge ? 24'(rem_q - {1'b0, mb_q}) : rem_q[23:0];

  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE);
    case (state_q)
      IDLE:    if (start) state_d = special ? DONE : DIV;
      DIV:     if (last_iter) state_d = NORM;
      NORM:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic signed [9:0] norm_exp;
  logic [22:0]       norm_frac;
  logic [31:0]       norm_res;

`ifdef FDIV_ROUND_EN
  logic [23:0]       mant;
  logic              guard, sticky;
  logic [24:0]       mant_r;
  logic signed [9:0] pre_exp;

  always_comb begin
    if (q_q[25]) begin
      mant    = q_q[25:2];
      guard   = q_q[1];
      sticky  = q_q[0] | (rem_q != 25'd0);
      pre_exp = exp_q;
    end else begin
      mant    = q_q[24:1];
      guard   = q_q[0];
      sticky  = (rem_q != 25'd0);
      pre_exp = exp_q - 10'sd1;
    end
    mant_r = {1'b0, mant} + {24'd0, guard & (sticky | mant[0])};
    // Carry out of the mantissa renormalises to 1.0 at the next exponent.
    if (mant_r[24]) begin
      norm_frac = mant_r[23:1];
      norm_exp  = pre_exp + 10'sd1;
    end else begin
      norm_frac = mant_r[22:0];
      norm_exp  = pre_exp;
    end
  end
`else
  always_comb begin
    if (q_q[24]) begin
      norm_frac = q_q[23:1];
      norm_exp  = exp_q;
    end else begin
      norm_frac = q_q[22:0];
      norm_exp  = exp_q - 10'sd1;
    end
  end
`endif

  always_comb begin
    if (norm_exp >= 10'sd255) begin
      norm_res = {sign_q, 8'hFF, 23'd0};
    end else if (norm_exp <= 10'sd0) begin
      norm_res = {sign_q, 31'd0};
    end else begin
      norm_res = {sign_q, norm_exp[7:0], norm_frac};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= 5'd0;
      rem_q       <= 25'd0;
      q_q         <= '0;
      mb_q        <= 24'd0;
      exp_q       <= 10'sd0;
      sign_q      <= 1'b0;
      spec_q      <= 1'b0;
      spec_dbz_q  <= 1'b0;
      spec_res_q  <= 32'd0;
      result      <= 32'd0;
      valid       <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sign_q     <= in_sign;
            spec_q     <= special;
            spec_res_q <= spec_res;
            spec_dbz_q <= spec_dbz;
            rem_q      <= {2'b01, a[22:0]};
            mb_q       <= {1'b1, b[22:0]};
            exp_q      <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
            cnt_q      <= 5'd0;
            q_q        <= '0;
          end
        end
        DIV: begin
          q_q   <= {q_q[NITER-2:0], ge};
          rem_q <= {rem_sub, 1'b0};
          cnt_q <= cnt_q + 5'd1;
        end
        NORM: begin
          result      <= norm_res;
          div_by_zero <= 1'b0;
          valid       <= 1'b1;
        end
        DONE: begin
          // Special results were resolved at acceptance and are published on leaving DONE.
          if (spec_q) begin
            result      <= spec_res_q;
            div_by_zero <= spec_dbz_q;
            valid       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float_divider_seq.sv
// Self-checking bench for float_divider_seq: scoreboard of expected quotients, flags and latencies.
module tb_float_divider_seq;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a     = 32'd0;
  logic [31:0] b     = 32'd0;
  logic [31:0] result;
  logic        valid;
  logic        busy;
  logic        div_by_zero;

  float_divider_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .result      (result),
    .valid       (valid),
    .busy        (busy),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

`ifdef FDIV_ROUND_EN
  localparam int          LN    = 27;
  localparam logic [31:0] THIRD = 32'h3EAAAAAB;
`else
  localparam int          LN    = 26;
  localparam logic [31:0] THIRD = 32'h3EAAAAAA;
`endif

  typedef struct {
    logic [31:0] res;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t  sb[$];
  string sb_name[$];
  int    checks  = 0;
  int    errors  = 0;
  int    cyc     = 0;
  int    acc_cyc = 0;
  int    pulses  = 0;

  always @(posedge clk) cyc++;
  always @(negedge clk) if (valid === 1'b1) pulses++;

  task automatic push(input string n, input logic [31:0] r, input logic d, input int l);
    exp_t e;
    e.res = r;
    e.dbz = d;
    e.lat = l;
    sb.push_back(e);
    sb_name.push_back(n);
  endtask

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib);
    a     = ia;
    b     = ib;
    start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1;
    checks += 4;
    if (result !== 32'd0) begin errors++; $display("FAIL reset result: got %h want 00000000", result); end
    if (valid !== 1'b0) begin errors++; $display("FAIL reset valid: got %b want 0", valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset div_by_zero: got %b want 0", div_by_zero); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL post_reset busy: got %b want 0", busy); end
    if (valid !== 1'b0) begin errors++; $display("FAIL post_reset valid: got %b want 0", valid); end
  endtask

  task automatic test_basic;
    exp_t e; string nm; bit ok;
    push("six_div_two", 32'h40400000, 1'b0, LN);
    issue(32'h40C00000, 32'h40000000);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic busy: got %b want 1", busy); end
    wait_valid(ok);
    e = sb.pop_front(); nm = sb_name.pop_front();
    checks++;
    if (!ok) begin errors++; $display("FAIL %s: no valid within bound", nm); end
    else begin
      checks += 3;
      if (result !== e.res) begin errors++; $display("FAIL %s result: got %h want %h", nm, result, e.res); end
      if (div_by_zero !== e.dbz) begin errors++; $display("FAIL %s div_by_zero: got %b want %b", nm, div_by_zero, e.dbz); end
      if (cyc - acc_cyc != e.lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", nm, cyc - acc_cyc, e.lat); end
    end
    @(posedge clk);
    #1;
    checks += 3;
    if (valid !== 1'b0) begin errors++; $display("FAIL basic valid_pulse: got %b want 0", valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL basic busy_after: got %b want 0", busy); end
    if (result !== 32'h40400000) begin errors++; $display("FAIL basic result_hold: got %h want 40400000", result); end
  endtask

  task automatic test_one_third;
    exp_t e; string nm; bit ok;
    push("one_third", THIRD, 1'b0, LN);
    issue(32'h3F800000, 32'h40400000);
    wait_valid(ok);
    e = sb.pop_front(); nm = sb_name.pop_front();
    checks++;
    if (!ok) begin errors++; $display("FAIL %s: no valid within bound", nm); end
    else begin
      checks += 3;
      if (result !== e.res) begin errors++; $display("FAIL %s result: got %h want %h", nm, result, e.res); end
      if (div_by_zero !== e.dbz) begin errors++; $display("FAIL %s div_by_zero: got %b want %b", nm, div_by_zero, e.dbz); end
      if (cyc - acc_cyc != e.lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", nm, cyc - acc_cyc, e.lat); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_specials;
    logic [31:0] ta [12] = '{32'hBF800000, 32'h3F800000, 32'h00000000, 32'h7F800000,
                             32'h7F800001, 32'hFF800000, 32'hBF800000, 32'h00000000,
                             32'h3F800000, 32'h00400000, 32'h3F800000, 32'h00800000};
    logic [31:0] tb [12] = '{32'h3F000000, 32'h00000000, 32'h00000000, 32'h7F800000,
                             32'h3F800000, 32'h40000000, 32'h00000000, 32'hBF800000,
                             32'hFF800000, 32'h3F800000, 32'h00400000, 32'h7F000000};
    logic [31:0] tr [12] = '{32'hC0000000, 32'h7F800000, 32'h7FC00000, 32'h7FC00000,
                             32'h7FC00000, 32'hFF800000, 32'hFF800000, 32'h80000000,
                             32'h80000000, 32'h00000000, 32'h7F800000, 32'h00000000};
    logic        td [12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int          tl [12] = '{LN, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, LN};
    exp_t e; string nm; bit ok;
    for (int i = 0; i < 12; i++) begin
      push($sformatf("case%0d_%h_%h", i, ta[i], tb[i]), tr[i], td[i], tl[i]);
      issue(ta[i], tb[i]);
      wait_valid(ok);
      e = sb.pop_front(); nm = sb_name.pop_front();
      checks++;
      if (!ok) begin errors++; $display("FAIL %s: no valid within bound", nm); end
      else begin
        checks += 3;
        if (result !== e.res) begin errors++; $display("FAIL %s result: got %h want %h", nm, result, e.res); end
        if (div_by_zero !== e.dbz) begin errors++; $display("FAIL %s div_by_zero: got %b want %b", nm, div_by_zero, e.dbz); end
        if (cyc - acc_cyc != e.lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", nm, cyc - acc_cyc, e.lat); end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_ignored_start;
    exp_t e; string nm; bit ok; int p0;
    push("ignored_start", 32'h40400000, 1'b0, LN);
    p0 = pulses;
    issue(32'h40C00000, 32'h40000000);
    repeat (5) @(posedge clk);
    #1;
    a     = 32'h3F800000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_valid(ok);
    e = sb.pop_front(); nm = sb_name.pop_front();
    checks++;
    if (!ok) begin errors++; $display("FAIL %s: no valid within bound", nm); end
    else begin
      checks += 3;
      if (result !== e.res) begin errors++; $display("FAIL %s result: got %h want %h", nm, result, e.res); end
      if (div_by_zero !== e.dbz) begin errors++; $display("FAIL %s div_by_zero: got %b want %b", nm, div_by_zero, e.dbz); end
      if (cyc - acc_cyc != e.lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", nm, cyc - acc_cyc, e.lat); end
    end
    repeat (30) @(posedge clk);
    #1;
    checks += 2;
    if (pulses - p0 != 1) begin errors++; $display("FAIL ignored_start pulses: got %0d want 1", pulses - p0); end
    if (busy !== 1'b0) begin errors++; $display("FAIL ignored_start busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_midop;
    exp_t e; string nm; bit ok; int p0;
    push("pre_reset_dbz", 32'h7F800000, 1'b1, 1);
    issue(32'h3F800000, 32'h00000000);
    wait_valid(ok);
    e = sb.pop_front(); nm = sb_name.pop_front();
    checks++;
    if (!ok) begin errors++; $display("FAIL %s: no valid within bound", nm); end
    else begin
      checks += 2;
      if (result !== e.res) begin errors++; $display("FAIL %s result: got %h want %h", nm, result, e.res); end
      if (div_by_zero !== e.dbz) begin errors++; $display("FAIL %s div_by_zero: got %b want %b", nm, div_by_zero, e.dbz); end
    end
    @(posedge clk);
    #1;
    issue(32'h40C00000, 32'h40000000);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (result !== 32'd0) begin errors++; $display("FAIL midop_reset result: got %h want 00000000", result); end
    if (valid !== 1'b0) begin errors++; $display("FAIL midop_reset valid: got %b want 0", valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL midop_reset busy: got %b want 0", busy); end
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL midop_reset div_by_zero: got %b want 0", div_by_zero); end
    p0 = pulses;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    checks += 2;
    if (pulses != p0) begin errors++; $display("FAIL midop_reset pulses: got %0d want 0", pulses - p0); end
    if (busy !== 1'b0) begin errors++; $display("FAIL midop_reset idle: got busy %b want 0", busy); end
    push("overflow", 32'h7F800000, 1'b0, LN);
    issue(32'h7F000000, 32'h00800000);
    wait_valid(ok);
    e = sb.pop_front(); nm = sb_name.pop_front();
    checks++;
    if (!ok) begin errors++; $display("FAIL %s: no valid within bound", nm); end
    else begin
      checks += 3;
      if (result !== e.res) begin errors++; $display("FAIL %s result: got %h want %h", nm, result, e.res); end
      if (div_by_zero !== e.dbz) begin errors++; $display("FAIL %s div_by_zero: got %b want %b", nm, div_by_zero, e.dbz); end
      if (cyc - acc_cyc != e.lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", nm, cyc - acc_cyc, e.lat); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    logic [31:0] ba [2] = '{32'h40C00000, 32'h3F800000};
    logic [31:0] bb [2] = '{32'h40000000, 32'h40400000};
    logic [31:0] br [2] = '{32'h40400000, THIRD};
    exp_t e; string nm; bit ok;
    for (int i = 0; i < 2; i++) begin
      push($sformatf("back_to_back%0d", i), br[i], 1'b0, LN);
      issue(ba[i], bb[i]);
      wait_valid(ok);
      e = sb.pop_front(); nm = sb_name.pop_front();
      checks++;
      if (!ok) begin errors++; $display("FAIL %s: no valid within bound", nm); end
      else begin
        checks += 3;
        if (result !== e.res) begin errors++; $display("FAIL %s result: got %h want %h", nm, result, e.res); end
        if (div_by_zero !== e.dbz) begin errors++; $display("FAIL %s div_by_zero: got %b want %b", nm, div_by_zero, e.dbz); end
        if (cyc - acc_cyc != e.lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", nm, cyc - acc_cyc, e.lat); end
      end
      // Next start lands in the first IDLE cycle after DONE.
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_one_third;
    test_specials;
    test_ignored_start;
    test_reset_midop;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "watchdog");
  end

endmodule
